exe_stage_unit: RTL and testbench

- Consumer end of the ID/EXE pipeline register: takes the decoded, registered instruction fields and executes them.
- Builds the second operand (immediate rotate, register shift, or memory offset), runs the ALU, and holds the NZCV status register.
- Resolves the branch target.
- Captures results in an internal EXE/MEM output register that feeds the memory stage.

---
 rtl/exe_stage_unit.sv | 146 ++++++++++++++
 tb/tb_exe_stage_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_unit.sv
// Execute stage: operand-2 generation, ALU with NZCV status register, branch target
// resolution and the EXE/MEM output register feeding the memory stage.
module exe_stage_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              WB_EN_IN,
   input  logic              MEM_R_EN_IN,
   input  logic              MEM_W_EN_IN,
   input  logic              B_IN,
   input  logic              S_IN,
   input  logic              imm_IN,
   input  logic [3:0]        EXE_CMD_IN,
   input  logic [DATA_W-1:0] PC_IN,
   input  logic [DATA_W-1:0] Val_Rn_IN,
   input  logic [DATA_W-1:0] Val_Rm_IN,
   input  logic [11:0]       Shift_operand_IN,
   input  logic [23:0]       Signed_imm_24_IN,
   input  logic [3:0]        Dest_IN,
   output logic              WB_EN,
   output logic              MEM_R_EN,
   output logic              MEM_W_EN,
   output logic [DATA_W-1:0] ALU_Res,
   output logic [DATA_W-1:0] Val_Rm,
   output logic [3:0]        Dest,
   output logic [3:0]        SR,
   output logic              Br_taken,
   output logic [DATA_W-1:0] Br_addr
);

   logic              wb_en_p1, mem_r_en_p1, mem_w_en_p1;
   logic [DATA_W-1:0] alu_res_p1, val_rm_p1;
   logic [3:0]        dest_p1, sr_p1;

   logic [DATA_W-1:0] val2_p0, alu_res_p0;
   logic [DATA_W:0]   sum_p0;
   logic              n_p0, z_p0, c_p0, v_p0, cmd_ok_p0, sr_load_p0;
   logic              mem_op_p0;

   function automatic logic [DATA_W-1:0] ror32(input logic [DATA_W-1:0] v, input logic [4:0] amt);
      logic [DATA_W-1:0] r;
      if (amt == 5'd0) r = v;
      else             r = (v >> amt) | (v << (6'd32 - {1'b0, amt}));
      return r;
   endfunction

   // Register-operand shifter; an amount of zero passes the operand through for every type.
   function automatic logic [DATA_W-1:0] shift_rm(input logic [DATA_W-1:0] v,
                                                  input logic [1:0] typ,
                                                  input logic [4:0] amt);
      logic signed [DATA_W-1:0] sv;
      logic        [DATA_W-1:0] r;
      sv = v;
      case (typ)
         2'b00:   r = v << amt;
         2'b01:   r = v >> amt;
         2'b10:   r = sv >>> amt;
         default: r = ror32(v, amt);
      endcase
      return r;
   endfunction

   assign mem_op_p0 = MEM_R_EN_IN | MEM_W_EN_IN;

   always_comb begin
      if (mem_op_p0)   val2_p0 = {20'b0, Shift_operand_IN};
      else if (imm_IN) val2_p0 = ror32({24'b0, Shift_operand_IN[7:0]}, {Shift_operand_IN[11:8], 1'b0});
      else             val2_p0 = shift_rm(Val_Rm_IN, Shift_operand_IN[6:5], Shift_operand_IN[11:7]);
   end

   // Subtraction is a + ~b + carry-in, so the carry out is already the NOT-borrow flag.
   always_comb begin
      alu_res_p0 = '0;
      sum_p0     = '0;
      c_p0       = sr_p1[1];
      v_p0       = sr_p1[0];
      cmd_ok_p0  = 1'b1;
      case (EXE_CMD_IN)
         4'b0001: alu_res_p0 = val2_p0;
         4'b1001: alu_res_p0 = ~val2_p0;
         4'b0010, 4'b0011: begin
            sum_p0     = {1'b0, Val_Rn_IN} + {1'b0, val2_p0}
                         + {{DATA_W{1'b0}}, (EXE_CMD_IN[0] & sr_p1[1])};
            alu_res_p0 = sum_p0[DATA_W-1:0];
            c_p0       = sum_p0[DATA_W];
            v_p0       = (Val_Rn_IN[DATA_W-1] == val2_p0[DATA_W-1]) &&
                         (alu_res_p0[DATA_W-1] != Val_Rn_IN[DATA_W-1]);
         end
         4'b0100, 4'b0101: begin
            sum_p0     = {1'b0, Val_Rn_IN} + {1'b0, ~val2_p0}
                         + {{DATA_W{1'b0}}, (EXE_CMD_IN[0] ? sr_p1[1] : 1'b1)};
            alu_res_p0 = sum_p0[DATA_W-1:0];
            c_p0       = sum_p0[DATA_W];
            v_p0       = (Val_Rn_IN[DATA_W-1] != val2_p0[DATA_W-1]) &&
                         (alu_res_p0[DATA_W-1] != Val_Rn_IN[DATA_W-1]);
         end
         4'b0110: alu_res_p0 = Val_Rn_IN & val2_p0;
         4'b0111: alu_res_p0 = Val_Rn_IN | val2_p0;
         4'b1000: alu_res_p0 = Val_Rn_IN ^ val2_p0;
         default: cmd_ok_p0  = 1'b0;
      endcase
      n_p0 = alu_res_p0[DATA_W-1];
      z_p0 = (alu_res_p0 == '0);
   end

   assign sr_load_p0 = S_IN & cmd_ok_p0 & ~freeze & ~flush & ~mem_op_p0;

   assign Br_taken = B_IN;
   assign Br_addr  = PC_IN + {{6{Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};

   // EXE/MEM boundary: flush inserts a bubble but still loads data; freeze holds everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en_p1    <= 1'b0;
         mem_r_en_p1 <= 1'b0;
         mem_w_en_p1 <= 1'b0;
         alu_res_p1  <= '0;
         val_rm_p1   <= '0;
         dest_p1     <= '0;
      end else if (flush || !freeze) begin
         wb_en_p1    <= WB_EN_IN & ~flush;
         mem_r_en_p1 <= MEM_R_EN_IN & ~flush;
         mem_w_en_p1 <= MEM_W_EN_IN & ~flush;
         alu_res_p1  <= alu_res_p0;
         val_rm_p1   <= Val_Rm_IN;
         dest_p1     <= Dest_IN;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            sr_p1 <= '0;
      else if (sr_load_p0) sr_p1 <= {n_p0, z_p0, c_p0, v_p0};
   end

   assign WB_EN    = wb_en_p1;
   assign MEM_R_EN = mem_r_en_p1;
   assign MEM_W_EN = mem_w_en_p1;
   assign ALU_Res  = alu_res_p1;
   assign Val_Rm   = val_rm_p1;
   assign Dest     = dest_p1;
   assign SR       = sr_p1;

endmodule

// File: tb/tb_exe_stage_unit.sv
// Directed-vector bench for exe_stage_unit: ALU/flag chain table plus freeze, flush and reset sequences.
module tb_exe_stage_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        freeze = 1'b0, flush = 1'b0;
   logic        WB_EN_IN = 1'b0, MEM_R_EN_IN = 1'b0, MEM_W_EN_IN = 1'b0;
   logic        B_IN = 1'b0, S_IN = 1'b0, imm_IN = 1'b0;
   logic [3:0]  EXE_CMD_IN = '0;
   logic [31:0] PC_IN = '0, Val_Rn_IN = '0, Val_Rm_IN = '0;
   logic [11:0] Shift_operand_IN = '0;
   logic [23:0] Signed_imm_24_IN = '0;
   logic [3:0]  Dest_IN = '0;
   logic        WB_EN, MEM_R_EN, MEM_W_EN, Br_taken;
   logic [31:0] ALU_Res, Val_Rm, Br_addr;
   logic [3:0]  Dest, SR;

   int checks = 0;
   int errors = 0;

   exe_stage_unit #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
      .B_IN(B_IN), .S_IN(S_IN), .imm_IN(imm_IN), .EXE_CMD_IN(EXE_CMD_IN),
      .PC_IN(PC_IN), .Val_Rn_IN(Val_Rn_IN), .Val_Rm_IN(Val_Rm_IN),
      .Shift_operand_IN(Shift_operand_IN), .Signed_imm_24_IN(Signed_imm_24_IN),
      .Dest_IN(Dest_IN), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest), .SR(SR),
      .Br_taken(Br_taken), .Br_addr(Br_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wb, mr, mw, b, s, imm;
      logic [3:0]  cmd;
      logic [31:0] pc, rn, rm;
      logic [11:0] sh;
      logic [23:0] imm24;
      logic [3:0]  dest;
      logic [31:0] exp_alu;
      logic [3:0]  exp_sr;
      logic [31:0] exp_br;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(logic wb, logic mr, logic mw, logic b, logic s, logic imm,
                               logic [3:0] cmd, logic [31:0] pc, logic [31:0] rn,
                               logic [31:0] rm, logic [11:0] sh, logic [23:0] imm24,
                               logic [3:0] dest, logic [31:0] exp_alu, logic [3:0] exp_sr,
                               logic [31:0] exp_br);
      vec_t v;
      v.wb = wb; v.mr = mr; v.mw = mw; v.b = b; v.s = s; v.imm = imm; v.cmd = cmd;
      v.pc = pc; v.rn = rn; v.rm = rm; v.sh = sh; v.imm24 = imm24; v.dest = dest;
      v.exp_alu = exp_alu; v.exp_sr = exp_sr; v.exp_br = exp_br;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic drive(input vec_t v);
      WB_EN_IN = v.wb; MEM_R_EN_IN = v.mr; MEM_W_EN_IN = v.mw; B_IN = v.b; S_IN = v.s;
      imm_IN = v.imm; EXE_CMD_IN = v.cmd; PC_IN = v.pc; Val_Rn_IN = v.rn; Val_Rm_IN = v.rm;
      Shift_operand_IN = v.sh; Signed_imm_24_IN = v.imm24; Dest_IN = v.dest;
   endtask

   initial begin
      //       wb mr mw b  s  imm cmd      pc         rn            rm            sh       imm24       dest  alu           sr       br
      tv.push_back(mk(1,0,0,0,1,1, 4'b0001, 32'h0,   32'h0,        32'h0,        12'h2FF, 24'h0,      4'd1, 32'hF000000F, 4'b1000, 32'h0));
      tv.push_back(mk(1,0,0,0,1,0, 4'b0100, 32'h0,   32'h3,        32'h5,        12'h000, 24'h0,      4'd2, 32'hFFFFFFFE, 4'b1000, 32'h0));
      tv.push_back(mk(1,0,0,0,1,1, 4'b0010, 32'h0,   32'hFFFFFFFF, 32'h0,        12'h001, 24'h0,      4'd3, 32'h00000000, 4'b0110, 32'h0));
      tv.push_back(mk(1,0,0,0,0,1, 4'b0011, 32'h0,   32'h1,        32'h0,        12'h001, 24'h0,      4'd4, 32'h00000003, 4'b0110, 32'h0));
      tv.push_back(mk(1,0,0,0,1,1, 4'b0101, 32'h0,   32'hA,        32'h0,        12'h003, 24'h0,      4'd5, 32'h00000007, 4'b0010, 32'h0));
      tv.push_back(mk(1,0,0,0,1,1, 4'b0100, 32'h0,   32'h0,        32'h0,        12'h001, 24'h0,      4'd6, 32'hFFFFFFFF, 4'b1000, 32'h0));
      tv.push_back(mk(1,0,0,0,1,1, 4'b0101, 32'h0,   32'h5,        32'h0,        12'h001, 24'h0,      4'd7, 32'h00000003, 4'b0010, 32'h0));
      tv.push_back(mk(1,0,0,0,1,1, 4'b0010, 32'h0,   32'h7FFFFFFF, 32'h0,        12'h001, 24'h0,      4'd8, 32'h80000000, 4'b1001, 32'h0));
      tv.push_back(mk(1,0,0,0,1,0, 4'b0110, 32'h0,   32'hF0F0F0F0, 32'hFF00FF00, 12'h000, 24'h0,      4'd1, 32'hF000F000, 4'b1001, 32'h0));
      tv.push_back(mk(1,0,0,0,0,1, 4'b0111, 32'h0,   32'h0000000F, 32'h0,        12'h0F0, 24'h0,      4'd2, 32'h000000FF, 4'b1001, 32'h0));
      tv.push_back(mk(1,0,0,0,1,1, 4'b1000, 32'h0,   32'h000000FF, 32'h0,        12'h0FF, 24'h0,      4'd3, 32'h00000000, 4'b0101, 32'h0));
      tv.push_back(mk(1,0,0,0,1,1, 4'b1001, 32'h0,   32'h0,        32'h0,        12'h000, 24'h0,      4'd4, 32'hFFFFFFFF, 4'b1001, 32'h0));
      tv.push_back(mk(1,0,0,0,0,0, 4'b0001, 32'h0,   32'h0,        32'h12345678, 12'h200, 24'h0,      4'd5, 32'h23456780, 4'b1001, 32'h0));
      tv.push_back(mk(1,0,0,0,0,0, 4'b0001, 32'h0,   32'h0,        32'h80000000, 12'h420, 24'h0,      4'd6, 32'h00800000, 4'b1001, 32'h0));
      tv.push_back(mk(1,0,0,0,0,0, 4'b0001, 32'h0,   32'h0,        32'h80000000, 12'h240, 24'h0,      4'd7, 32'hF8000000, 4'b1001, 32'h0));
      tv.push_back(mk(1,0,0,0,0,0, 4'b0001, 32'h0,   32'h0,        32'h12345678, 12'h460, 24'h0,      4'd8, 32'h78123456, 4'b1001, 32'h0));
      tv.push_back(mk(1,0,0,0,0,0, 4'b0001, 32'h0,   32'h0,        32'h80000000, 12'h040, 24'h0,      4'd9, 32'h80000000, 4'b1001, 32'h0));
      tv.push_back(mk(1,1,0,0,1,0, 4'b0010, 32'h0,   32'h00001000, 32'h0,        12'hFFC, 24'h0,      4'd1, 32'h00001FFC, 4'b1001, 32'h0));
      tv.push_back(mk(0,0,1,0,1,1, 4'b0010, 32'h0,   32'h00002000, 32'h0000DEAD, 12'h104, 24'h0,      4'd2, 32'h00002104, 4'b1001, 32'h0));
      tv.push_back(mk(0,0,0,1,0,0, 4'b0000, 32'h100, 32'h0,        32'h0,        12'h000, 24'hFFFFFE, 4'd0, 32'h00000000, 4'b1001, 32'hF8));
      tv.push_back(mk(1,0,0,1,0,1, 4'b0001, 32'h200, 32'h0,        32'h0,        12'h001, 24'h000010, 4'd3, 32'h00000001, 4'b1001, 32'h240));
      tv.push_back(mk(1,0,0,0,1,0, 4'b1111, 32'h0,   32'h5,        32'h0,        12'h000, 24'h0,      4'd9, 32'h00000000, 4'b1001, 32'h0));

      // Power-on reset state.
      #2;
      chk("reset_alu", ALU_Res, 32'h0);
      chk("reset_sr", {28'h0, SR}, 32'h0);
      chk("reset_wb", {31'h0, WB_EN}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      foreach (tv[i]) begin
         @(negedge clk);
         drive(tv[i]);
         #1;
         chk($sformatf("br_taken[%0d]", i), {31'h0, Br_taken}, {31'h0, tv[i].b});
         if (tv[i].b) chk($sformatf("br_addr[%0d]", i), Br_addr, tv[i].exp_br);
         @(posedge clk);
         #1;
         chk($sformatf("alu[%0d]", i), ALU_Res, tv[i].exp_alu);
         chk($sformatf("sr[%0d]", i), {28'h0, SR}, {28'h0, tv[i].exp_sr});
         chk($sformatf("wb[%0d]", i), {31'h0, WB_EN}, {31'h0, tv[i].wb});
         chk($sformatf("mr[%0d]", i), {31'h0, MEM_R_EN}, {31'h0, tv[i].mr});
         chk($sformatf("mw[%0d]", i), {31'h0, MEM_W_EN}, {31'h0, tv[i].mw});
         chk($sformatf("dest[%0d]", i), {28'h0, Dest}, {28'h0, tv[i].dest});
         chk($sformatf("val_rm[%0d]", i), Val_Rm, tv[i].rm);
      end

      // Freeze for three cycles with changing inputs: everything holds the last table entry.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         freeze = 1'b1;
         drive(mk(0,1,0,0,1,1, 4'b0010, 32'h0, 32'(k + 1), 32'(k + 7), 12'h011, 24'h0, 4'(k + 4),
                  32'h0, 4'h0, 32'h0));
         @(posedge clk);
         #1;
         chk("frz_alu", ALU_Res, 32'h0);
         chk("frz_sr", {28'h0, SR}, {28'h0, 4'b1001});
         chk("frz_wb", {31'h0, WB_EN}, 32'h1);
         chk("frz_mr", {31'h0, MEM_R_EN}, 32'h0);
         chk("frz_dest", {28'h0, Dest}, 32'h9);
      end

      // Flush wins over freeze: bubble in control, data still loads, SR untouched.
      @(negedge clk);
      freeze = 1'b1; flush = 1'b1;
      drive(mk(1,1,1,0,1,1, 4'b0001, 32'h0, 32'h0, 32'h0, 12'h055, 24'h0, 4'd3, 32'h0, 4'h0, 32'h0));
      @(posedge clk);
      #1;
      chk("flush_wb", {31'h0, WB_EN}, 32'h0);
      chk("flush_mr", {31'h0, MEM_R_EN}, 32'h0);
      chk("flush_mw", {31'h0, MEM_W_EN}, 32'h0);
      chk("flush_alu", ALU_Res, 32'h55);
      chk("flush_dest", {28'h0, Dest}, 32'h3);
      chk("flush_sr", {28'h0, SR}, {28'h0, 4'b1001});

      @(negedge clk);
      freeze = 1'b0; flush = 1'b0;
      drive(mk(1,0,0,0,1,1, 4'b0001, 32'h0, 32'h0, 32'h0, 12'h077, 24'h0, 4'd6, 32'h0, 4'h0, 32'h0));
      @(posedge clk);
      #1;
      chk("pre_rst_alu", ALU_Res, 32'h77);
      chk("pre_rst_sr", {28'h0, SR}, {28'h0, 4'b0001});

      // Asynchronous reset in the middle of a frozen cycle.
      @(negedge clk);
      freeze = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_alu", ALU_Res, 32'h0);
      chk("async_rst_sr", {28'h0, SR}, 32'h0);
      chk("async_rst_wb", {31'h0, WB_EN}, 32'h0);
      chk("async_rst_dest", {28'h0, Dest}, 32'h0);
      chk("async_rst_valrm", Val_Rm, 32'h0);
      freeze = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_hold_alu", ALU_Res, 32'h0);
      chk("rst_hold_wb", {31'h0, WB_EN}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_alu", ALU_Res, 32'h77);
      chk("post_rst_sr", {28'h0, SR}, 32'h0);
      chk("post_rst_wb", {31'h0, WB_EN}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
